// File: rtl/bitwise_result_stage_if.sv
// Handshake bundle for the BitWise result stage: upstream result in, annotated head entry out.
interface bitwise_result_stage_if #(
  parameter int N     = 32,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_c;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_data;
  logic             out_zero;
  logic             out_ones;
  logic             out_parity;
  logic [CNT_W-1:0] accept_count;

  modport slave (
    input  in_valid, in_c, out_ready,
    output in_ready, out_valid, out_data, out_zero, out_ones, out_parity, accept_count
  );

  modport master (
    output in_valid, in_c, out_ready,
    input  in_ready, out_valid, out_data, out_zero, out_ones, out_parity, accept_count
  );
endinterface

// File: rtl/bitwise_result_stage.sv
// Registered result stage: 2-entry skid buffer that tags each BitWise result with
// zero / all-ones / parity flags and counts accepted results.
//
//   state | meaning
//   EMPTY | no entry buffered, out_valid=0
//   ONE   | head entry valid, second slot free
//   FULL  | head and second slot valid, in_ready=0
module bitwise_result_stage #(
  parameter int N     = 32,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  bitwise_result_stage_if.slave  bus
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t           state, state_nxt;
  logic [N+2:0]     head_q, second_q;   // {parity, ones, zero, data}
  logic [N+2:0]     in_entry;
  logic             in_ready_q;
  logic [CNT_W-1:0] count_q;
  logic             out_valid_c;
  logic             push, pop;
  logic             load_head_in, load_second, head_from_second;

  assign in_entry = {^bus.in_c, &bus.in_c, ~|bus.in_c, bus.in_c};
  assign push     = bus.in_valid & in_ready_q;
  assign pop      = out_valid_c & bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (push) state_nxt = ONE;
      ONE:     if (push && !pop) state_nxt = FULL;
               else if (!push && pop) state_nxt = EMPTY;
      FULL:    if (pop) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    out_valid_c      = (state != EMPTY);
    load_head_in     = 1'b0;
    load_second      = 1'b0;
    head_from_second = 1'b0;
    case (state)
      EMPTY:   load_head_in = push;
      ONE: begin
        load_head_in = push & pop;
        load_second  = push & ~pop;
      end
      FULL:    head_from_second = pop;
      default: ;
    endcase
  end

  // in_ready is a flop off next-state so out_ready never reaches it combinationally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_q <= 1'b0;
      count_q    <= '0;
      head_q     <= '0;
      second_q   <= '0;
    end else begin
      in_ready_q <= (state_nxt != FULL);
      if (push)             count_q  <= count_q + CNT_W'(1);
      if (load_head_in)     head_q   <= in_entry;
      if (head_from_second) head_q   <= second_q;
      if (load_second)      second_q <= in_entry;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_c;
  assign bus.out_data     = head_q[N-1:0];
  assign bus.out_zero     = head_q[N];
  assign bus.out_ones     = head_q[N+1];
  assign bus.out_parity   = head_q[N+2];
  assign bus.accept_count = count_q;
endmodule

// File: tb/tb_bitwise_result_stage.sv
// Scoreboard bench for bitwise_result_stage at N=8, CNT_W=4.
module tb_bitwise_result_stage;
  localparam int N  = 8;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bitwise_result_stage_if #(.N(N), .CNT_W(CW)) bus();
  bitwise_result_stage #(.N(N), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [N+2:0]  sb[$];
  logic [CW-1:0] exp_cnt;
  int errors = 0;
  int checks = 0;

  function automatic logic [N+2:0] model(input logic [N-1:0] c);
    logic z, o, p;
    z = 1'b1; o = 1'b1; p = 1'b0;
    for (int i = 0; i < N; i++) begin
      z = z & ~c[i];
      o = o & c[i];
      p = p ^ c[i];
    end
    return {p, o, z, c};
  endfunction

  function automatic logic [N+2:0] observed();
    return {bus.out_parity, bus.out_ones, bus.out_zero, bus.out_data};
  endfunction

  // Records handshakes that will occur on the coming edge, then advances one cycle.
  task automatic tick();
    logic [N+2:0] dropped;
    if (bus.in_valid && bus.in_ready) begin
      sb.push_back(model(bus.in_c));
      exp_cnt = exp_cnt + 1'b1;
    end
    if (bus.out_valid && bus.out_ready && sb.size() > 0) dropped = sb.pop_front();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.in_valid = 1'b0; bus.in_c = '0; bus.out_ready = 1'b0;
    sb.delete(); exp_cnt = '0;
    repeat (3) tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h want 00", bus.out_data); end
    checks++; if ({bus.out_parity, bus.out_ones, bus.out_zero} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {bus.out_parity, bus.out_ones, bus.out_zero}); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
    checks++; if (bus.accept_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.accept_count); end
    rst = 1'b0;
    bus.in_valid = 1'b1; bus.in_c = 8'h99;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL release_in_ready_early: got %b want 0", bus.in_ready); end
    tick();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b want 1", bus.in_ready); end
    checks++; if (bus.accept_count !== 4'd0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL release_no_accept: got count %0d valid %b want 0 0", bus.accept_count, bus.out_valid); end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_flags();
    logic [7:0] vals [3];
    logic [2:0] fl   [3];
    vals = '{8'hFF, 8'h00, 8'h07};
    fl   = '{3'b010, 3'b001, 3'b100};   // {parity, ones, zero}
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.in_c = vals[i];
      tick();
      bus.in_valid = 1'b0;
      checks++; if (bus.out_valid !== 1'b1 || observed() !== {fl[i], vals[i]}) begin
        errors++; $display("FAIL flags_%0d: got valid %b entry %h want valid 1 entry %h", i, bus.out_valid, observed(), {fl[i], vals[i]});
      end
      checks++; if (bus.accept_count !== CW'(i + 1)) begin errors++; $display("FAIL flags_count_%0d: got %0d want %0d", i, bus.accept_count, i + 1); end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [7:0]    want [3];
    logic [CW-1:0] cnt0;
    logic          pushed;
    int            got;
    want = '{8'h11, 8'h22, 8'h33};
    cnt0 = exp_cnt;
    got  = 0;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_c = 8'h11; tick();
    bus.in_c = 8'h22; tick();
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b want 0", bus.in_ready); end
    checks++; if (bus.out_data !== 8'h11) begin errors++; $display("FAIL full_head: got %h want 11", bus.out_data); end
    bus.in_c = 8'h33;
    repeat (3) tick();
    checks++; if (bus.accept_count !== CW'(cnt0 + 2)) begin errors++; $display("FAIL full_ignore_count: got %0d want %0d", bus.accept_count, CW'(cnt0 + 2)); end
    checks++; if (bus.out_data !== 8'h11 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL full_stable: got %h valid %b want 11 valid 1", bus.out_data, bus.out_valid); end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 12 && got < 3; k++) begin
      pushed = bus.in_valid && bus.in_ready;
      if (bus.out_valid) begin
        checks++; if (observed() !== model(want[got]) || sb.size() == 0 || sb[0] !== model(want[got])) begin
          errors++; $display("FAIL drain_%0d: got %h want %h", got, observed(), model(want[got]));
        end
        got++;
      end
      tick();
      if (pushed) bus.in_valid = 1'b0;
    end
    checks++; if (got != 3) begin errors++; $display("FAIL drain_count: got %0d outputs want 3", got); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL drain_dup: got valid %b want 0", bus.out_valid); end
    checks++; if (bus.accept_count !== CW'(cnt0 + 3)) begin errors++; $display("FAIL drain_total: got %0d want %0d", bus.accept_count, CW'(cnt0 + 3)); end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_push_pop();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_c = 8'hA5; tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_data !== 8'hA5) begin errors++; $display("FAIL pp_head: got %h want a5", bus.out_data); end
    bus.in_valid = 1'b1; bus.in_c = 8'h5A; bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h5A || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL pp_swap: got valid %b data %h ready %b want 1 5a 1", bus.out_valid, bus.out_data, bus.in_ready);
    end
    checks++; if (sb.size() != 1 || observed() !== sb[0]) begin errors++; $display("FAIL pp_scoreboard: got %h want %h", observed(), model(8'h5A)); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL pp_empty: got valid %b want 0", bus.out_valid); end
  endtask

  task automatic test_stream();
    rst = 1'b1; bus.in_valid = 1'b0; sb.delete(); exp_cnt = '0;
    tick();
    rst = 1'b0;
    tick();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.in_valid = 1'b1; bus.in_c = 8'(8'h40 + i);
      if (i > 0) begin
        checks++; if (bus.out_valid !== 1'b1 || sb.size() == 0 || observed() !== sb[0] || bus.out_data !== 8'(8'h40 + i - 1)) begin
          errors++; $display("FAIL stream_%0d: got valid %b data %h want valid 1 data %h", i, bus.out_valid, bus.out_data, 8'(8'h40 + i - 1));
        end
      end
      tick();
    end
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h53) begin errors++; $display("FAIL stream_last: got %h want 53", bus.out_data); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stream_empty: got valid %b want 0", bus.out_valid); end
    checks++; if (bus.accept_count !== 4'd4) begin errors++; $display("FAIL stream_wrap: got %0d want 4", bus.accept_count); end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_c = 8'hE1; tick();
    bus.in_c = 8'hE2; tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL mid_full: got ready %b valid %b want 0 1", bus.in_ready, bus.out_valid); end
    #3 rst = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.accept_count !== 4'd0 || bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL mid_async_clear: got valid %b count %0d ready %b want 0 0 0", bus.out_valid, bus.accept_count, bus.in_ready);
    end
    sb.delete(); exp_cnt = '0;
    tick();
    rst = 1'b0;
    tick();
    bus.in_valid = 1'b1; bus.in_c = 8'hC3; bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || observed() !== model(8'hC3)) begin errors++; $display("FAIL mid_first_after: got valid %b entry %h want 1 %h", bus.out_valid, observed(), model(8'hC3)); end
    checks++; if (bus.accept_count !== 4'd1) begin errors++; $display("FAIL mid_count: got %0d want 1", bus.accept_count); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_no_stale: got valid %b want 0", bus.out_valid); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0; bus.in_c = '0; bus.out_ready = 1'b0;
    test_reset();
    test_flags();
    test_backpressure();
    test_push_pop();
    test_stream();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
